// File: rtl/seg7_scan_ctrl.sv
// Scan sequencer for an 8-digit multiplexed 7-segment display: walks the enabled digits,
// blanks the start of every slot, and gates blinking digits off on alternate blink phases.
module seg7_scan_ctrl #(
  parameter int DIV       = 1000,
  parameter int BLANK     = 16,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] digit_mask,
  input  logic [7:0] blink_mask,
  output logic [2:0] sel,
  output logic [7:0] dig_en,
  output logic       seg_blank,
  output logic       frame_tick,
  output logic       blink_phase
);

  localparam int SLOT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FRM_W  = $clog2(BLINK_DIV + 1);

  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIV - 1);
  localparam logic [FRM_W-1:0]  FRM_WRAP   = FRM_W'(BLINK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [FRM_W-1:0]    frm_cnt_q, frm_cnt_d;
  logic [FRM_W-1:0]    frm_inc;
  logic                blink_phase_q, blink_phase_d;
  logic                frame_tick_q, frame_tick_d;
  logic [7:0]          dig_en_q, dig_en_d;
  logic                seg_blank_q, seg_blank_d;

  logic [2:0]          first_sel;
  logic [2:0]          nxt_sel;
  logic                nxt_found;
  logic [2:0]          scan_idx;

  // Lowest enabled digit: where every frame (and every restart) begins.
  always_comb begin
    first_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (digit_mask[i]) first_sel = 3'(i);
    end
  end

  // Next enabled digit strictly above sel, wrapping; i=8 lands back on sel itself.
  always_comb begin
    nxt_sel   = sel_q;
    nxt_found = 1'b0;
    scan_idx  = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      scan_idx = sel_q + 3'(i);
      if (!nxt_found && digit_mask[scan_idx]) begin
        nxt_sel   = scan_idx;
        nxt_found = 1'b1;
      end
    end
  end

  assign frm_inc = frm_cnt_q + FRM_W'(1);

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    slot_cnt_d    = slot_cnt_q;
    frm_cnt_d     = frm_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_tick_d  = 1'b0;

    if (!en) begin
      state_d    = S_IDLE;
      slot_cnt_d = '0;
      frm_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|digit_mask) begin
            state_d      = S_BLANK;
            sel_d        = first_sel;
            frame_tick_d = 1'b1;
            slot_cnt_d   = '0;
          end
        end
        S_BLANK: begin
          slot_cnt_d = slot_cnt_q + SLOT_W'(1);
          if (slot_cnt_q == BLANK_LAST) state_d = S_ON;
        end
        S_ON: begin
          if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            if (digit_mask == 8'h00) begin
              state_d   = S_IDLE;
              frm_cnt_d = '0;
            end else begin
              state_d = S_BLANK;
              sel_d   = nxt_sel;
              // Wrapping to a digit at or below the current one starts a new frame.
              if (nxt_sel <= sel_q) begin
                frame_tick_d = 1'b1;
                if (frm_inc == FRM_WRAP) begin
                  frm_cnt_d     = '0;
                  blink_phase_d = ~blink_phase_q;
                end else begin
                  frm_cnt_d = frm_inc;
                end
              end
            end
          end else begin
            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
          end
        end
        default: begin
          state_d    = S_IDLE;
          slot_cnt_d = '0;
          frm_cnt_d  = '0;
        end
      endcase
    end

    // Output registers are loaded from the next state so they line up with it.
    dig_en_d    = 8'h00;
    seg_blank_d = 1'b1;
    if (state_d == S_ON && !(blink_mask[sel_d] && blink_phase_d)) begin
      dig_en_d    = 8'h01 << sel_d;
      seg_blank_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sel_q         <= 3'd0;
      slot_cnt_q    <= '0;
      frm_cnt_q     <= '0;
      blink_phase_q <= 1'b0;
      frame_tick_q  <= 1'b0;
      dig_en_q      <= 8'h00;
      seg_blank_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      slot_cnt_q    <= slot_cnt_d;
      frm_cnt_q     <= frm_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_tick_q  <= frame_tick_d;
      dig_en_q      <= dig_en_d;
      seg_blank_q   <= seg_blank_d;
    end
  end

  assign sel         = sel_q;
  assign dig_en      = dig_en_q;
  assign seg_blank   = seg_blank_q;
  assign frame_tick  = frame_tick_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIV=8, BLANK=2, BLINK_DIV=2; outputs sampled on the falling edge.
module tb_seg7_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] digit_mask = 8'h00;
  logic [7:0] blink_mask = 8'h00;
  logic [2:0] sel;
  logic [7:0] dig_en;
  logic       seg_blank;
  logic       frame_tick;
  logic       blink_phase;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(.DIV(8), .BLANK(2), .BLINK_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digit_mask (digit_mask),
    .blink_mask (blink_mask),
    .sel        (sel),
    .dig_en     (dig_en),
    .seg_blank  (seg_blank),
    .frame_tick (frame_tick),
    .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".sel"},         {5'd0, sel},         8'h00);
    chk({tag, ".dig_en"},      dig_en,              8'h00);
    chk({tag, ".seg_blank"},   {7'd0, seg_blank},   8'h01);
    chk({tag, ".frame_tick"},  {7'd0, frame_tick},  8'h00);
    chk({tag, ".blink_phase"}, {7'd0, blink_phase}, 8'h00);
  endtask

  // One full 8-cycle slot of digit d: 2 blank cycles then 6 lit (unless off).
  task automatic expect_slot(input int d, input bit ft, input bit bl, input bit off,
                             input logic [7:0] mask_after);
    logic lit;
    for (int c = 0; c < 8; c++) begin
      tick();
      lit = (c >= 2) && !off;
      chk($sformatf("d%0d.c%0d.sel", d, c),    {5'd0, sel}, 8'(d));
      chk($sformatf("d%0d.c%0d.dig_en", d, c), dig_en, lit ? (8'h01 << d) : 8'h00);
      chk($sformatf("d%0d.c%0d.seg_blank", d, c), {7'd0, seg_blank}, {7'd0, !lit});
      chk($sformatf("d%0d.c%0d.frame_tick", d, c), {7'd0, frame_tick}, {7'd0, ft && (c == 0)});
      chk($sformatf("d%0d.c%0d.blink", d, c), {7'd0, blink_phase}, {7'd0, bl});
      if (c == 3) digit_mask = mask_after;
    end
  endtask

  task automatic chk_idle(input string tag, input logic [2:0] exp_sel, input bit exp_bl);
    chk({tag, ".sel"},         {5'd0, sel},         {5'd0, exp_sel});
    chk({tag, ".dig_en"},      dig_en,              8'h00);
    chk({tag, ".seg_blank"},   {7'd0, seg_blank},   8'h01);
    chk({tag, ".frame_tick"},  {7'd0, frame_tick},  8'h00);
    chk({tag, ".blink_phase"}, {7'd0, blink_phase}, {7'd0, exp_bl});
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 chk_reset_vals(tag);
    en         = 1'b0;
    blink_mask = 8'h00;
    @(negedge clk);
    chk_reset_vals({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    // Power-up reset
    #1 rst = 1'b1;
    #2 chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_idle("idle_en0", 3'd0, 1'b0);

    // Full mask: all eight digits, one frame plus the start of the next
    digit_mask = 8'hFF;
    en         = 1'b1;
    for (int d = 0; d < 8; d++) expect_slot(d, d == 0, 1'b0, 1'b0, 8'hFF);
    expect_slot(0, 1'b1, 1'b0, 1'b0, 8'hFF);
    expect_slot(1, 1'b0, 1'b0, 1'b0, 8'hFF);
    expect_slot(2, 1'b0, 1'b0, 1'b0, 8'hFF);

    // Drop en during digit 3's first lit cycle
    tick(); tick(); tick();
    chk("d3.on.dig_en", dig_en, 8'h08);
    en = 1'b0;
    tick();
    chk_idle("en_drop", 3'd3, 1'b0);
    tick();
    chk_idle("en_drop2", 3'd3, 1'b0);

    // Re-enable restarts at the lowest digit with a full blank interval
    en = 1'b1;
    expect_slot(0, 1'b1, 1'b0, 1'b0, 8'hFF);
    tick(); tick(); tick();
    chk("d1.on.dig_en", dig_en, 8'h02);
    async_reset("rst_mid_on");

    // Sparse mask 0x05, then blinking on digit 0
    digit_mask = 8'h05;
    en         = 1'b1;
    expect_slot(0, 1'b1, 1'b0, 1'b0, 8'h05);
    expect_slot(2, 1'b0, 1'b0, 1'b0, 8'h05);
    expect_slot(0, 1'b1, 1'b0, 1'b0, 8'h05);
    expect_slot(2, 1'b0, 1'b0, 1'b0, 8'h05);
    blink_mask = 8'h01;
    expect_slot(0, 1'b1, 1'b1, 1'b1, 8'h05);
    expect_slot(2, 1'b0, 1'b1, 1'b0, 8'h05);
    expect_slot(0, 1'b1, 1'b1, 1'b1, 8'h05);
    expect_slot(2, 1'b0, 1'b1, 1'b0, 8'h05);
    expect_slot(0, 1'b1, 1'b0, 1'b0, 8'h05);
    en = 1'b0;
    tick();
    chk_idle("blink_done", 3'd0, 1'b0);
    async_reset("rst2");

    // Single digit 7, then mask cleared mid-slot
    digit_mask = 8'h80;
    en         = 1'b1;
    expect_slot(7, 1'b1, 1'b0, 1'b0, 8'h80);
    expect_slot(7, 1'b1, 1'b0, 1'b0, 8'h80);
    expect_slot(7, 1'b1, 1'b1, 1'b0, 8'h80);
    expect_slot(7, 1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    chk_idle("mask0_idle", 3'd7, 1'b1);
    tick();
    chk_idle("mask0_idle2", 3'd7, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
